mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_CYCLES, default 2, clocks mem_en is held per access (range 1-4).
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req0 / req1  in  1  access request from port 0 (CPU control FSM) / port 1 (program loader / debug).
REQ-005 we0 / we1  in  1  1 = write, 0 = read, per port.
REQ-006 addr0 / addr1  in  16  word address, per port.
REQ-007 wdata0 / wdata1  in  16  write data, per port.
REQ-008 ack0 / ack1  out  1  one-cycle completion pulse, per port.
REQ-009 rdata  out  16  registered read data, valid while the matching ack is high.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 mem_en  out  1  memory enable to the memory array.
REQ-012 mem_rw  out  1  1 = write, 0 = read.
REQ-013 mem_addr  out  16  latched address of the granted access.
REQ-014 mem_wdata  out  16  latched write data of the granted access.
REQ-015 mem_rdata  in  16  memory read data, valid in the last enable cycle.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-017 IDLE: at a posedge with req0 or req1 high, the FSM SHALL pick a winner, latch its we/addr/wdata into mem_rw/mem_addr/mem_wdata, set owner, and go to ACCESS; with neither high it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the port not granted last wins; with one request high, that port wins regardless of history.
REQ-019 The last-grant pointer SHALL update only on a grant.
REQ-020 ACCESS: mem_en SHALL be high (registered) for exactly MEM_CYCLES clocks; a 2-bit cycle counter SHALL count from 0 to MEM_CYCLES-1.
REQ-021 On the posedge ending the last ACCESS cycle, the block SHALL capture mem_rdata into rdata (reads only), set ack of the owner, drop mem_en, and go to RESP.
REQ-022 On writes, rdata SHALL hold its previous value.
REQ-023 RESP: lasts one cycle; the ack of the owner SHALL be high and the other ack low; the next posedge SHALL return to IDLE and clear the ack.
REQ-024 Latency: a request sampled at edge N SHALL give mem_en high in cycles N+1 to N+MEM_CYCLES, with ack high in cycle N+MEM_CYCLES+1; throughput is one access per MEM_CYCLES+2 clocks.
REQ-025 Requests SHALL be ignored in ACCESS and RESP; a requester SHALL hold req, we, addr and wdata until its ack, then deassert req at that edge, or keep req high to request again.
REQ-026 Changes to addr/wdata/we after the grant SHALL NOT affect the access in progress.
REQ-027 A req held across RESP SHALL be re-arbitrated in IDLE; if both ports are requesting, the other port SHALL win.
REQ-028 ack0 and ack1 SHALL never be high together; mem_en SHALL never be high outside ACCESS.

Reset
REQ-029 While rst is high, asynchronously: state=IDLE, mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0, rdata=0, ack0=ack1=0, busy=0, counter=0, and the last-grant pointer set to port 1, so port 0 wins the first tie.
REQ-030 Reset during ACCESS or RESP SHALL abort the access with no ack issued; mem_en SHALL fall in the same cycle as rst rises.

Verification (MEM_CYCLES=2)
REQ-031 Single read: port 0 reads addr 0x3000 (mem holds 0x1234) -> mem_en high 2 cycles with mem_addr=0x3000 and mem_rw=0; then ack0 for one cycle with rdata=0x1234; ack1 stays 0.
REQ-032 Single write: port 1 writes 0xBEEF to 0x0010 -> mem_rw=1 and mem_wdata=0xBEEF through both enable cycles; ack1 pulses; rdata unchanged.
REQ-033 Tie after reset: req0 and req1 raised on the same edge -> port 0 served first; port 1 served next with its grant 4 clocks after port 0's; both keep req high -> grants alternate 0,1,0,1.
REQ-034 Mid-access change: port 0 changes addr0 from 0x3000 to 0x4000 during ACCESS -> mem_addr stays 0x3000 until the next grant.
REQ-035 Reset abort: assert rst during the second ACCESS cycle -> mem_en=0 and busy=0 at once, no ack; after rst falls, a held req0 is granted normally.
REQ-036 Idle: no requests for 20 clocks -> mem_en, busy and ack stay 0, and state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-port memory
// A grant latches the winner's command; mem_en is held for MEM_CYCLES clocks, then one ack cycle follows.
module mem_arbiter #(
    parameter int MEM_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] LAST_CNT = 2'(MEM_CYCLES - 1);

    state_t      state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic        owner, owner_nx;
    logic        last_grant, last_grant_nx;
    logic        win;
    logic        ack0_nx, ack1_nx, mem_en_nx, mem_rw_nx;
    logic [15:0] mem_addr_nx, mem_wdata_nx, rdata_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            mem_en     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            rdata      <= 16'h0000;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            owner      <= owner_nx;
            last_grant <= last_grant_nx;
            ack0       <= ack0_nx;
            ack1       <= ack1_nx;
            mem_en     <= mem_en_nx;
            mem_rw     <= mem_rw_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            rdata      <= rdata_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        owner_nx      = owner;
        last_grant_nx = last_grant;
        ack0_nx       = 1'b0;
        ack1_nx       = 1'b0;
        mem_en_nx     = mem_en;
        mem_rw_nx     = mem_rw;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        rdata_nx      = rdata;
        // On a tie the port that did not win last time gets the grant.
        win           = (req0 && req1) ? ~last_grant : req1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_nx      = win;
                    last_grant_nx = win;
                    mem_rw_nx     = win ? we1 : we0;
                    mem_addr_nx   = win ? addr1 : addr0;
                    mem_wdata_nx  = win ? wdata1 : wdata0;
                    mem_en_nx     = 1'b1;
                    cnt_nx        = 2'd0;
                    state_nx      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == LAST_CNT) begin
                    if (!mem_rw) begin
                        rdata_nx = mem_rdata;
                    end
                    ack0_nx   = ~owner;
                    ack1_nx   = owner;
                    mem_en_nx = 1'b0;
                    cnt_nx    = 2'd0;
                    state_nx  = RESP;
                end else begin
                    cnt_nx = cnt + 2'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx  = IDLE;
                mem_en_nx = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int MEM_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, busy, mem_en, mem_rw;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic        m_last;
    logic [15:0] m_rdata;

    mem_arbiter #(.MEM_CYCLES(MEM_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memval(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : ((a ^ 16'hA5C3) + 16'h0011);
    endfunction

    assign mem_rdata = memval(mem_addr);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One arbitration round starting with the DUT idle; expectations come from the round-robin rule.
    task automatic txn(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic scr, input logic hold);
        logic        win;
        logic        e_we;
        logic [15:0] e_a, e_d;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        step();
        if (!r0 && !r1) begin
            check("noreq_busy", 16'(busy), 16'd0);
            check("noreq_en", 16'(mem_en), 16'd0);
            return;
        end
        win    = (r0 && r1) ? !m_last : r1;
        m_last = win;
        e_we   = win ? w1 : w0;
        e_a    = win ? a1 : a0;
        e_d    = win ? d1 : d0;
        check("grant_en", 16'(mem_en), 16'd1);
        check("grant_busy", 16'(busy), 16'd1);
        check("grant_addr", mem_addr, e_a);
        check("grant_rw", 16'(mem_rw), 16'(e_we));
        check("grant_wdata", mem_wdata, e_d);
        check("grant_acks", {14'd0, ack1, ack0}, 16'd0);
        if (scr) begin
            addr0 = addr0 + 16'h1000; addr1 = addr1 + 16'h1000;
            wdata0 = ~wdata0; wdata1 = ~wdata1; we0 = ~we0; we1 = ~we1;
        end
        for (int c = 1; c < MEM_CYCLES; c++) begin
            step();
            check("acc_en", 16'(mem_en), 16'd1);
            check("acc_addr", mem_addr, e_a);
            check("acc_wdata", mem_wdata, e_d);
            check("acc_rw", 16'(mem_rw), 16'(e_we));
        end
        step();
        if (!e_we) m_rdata = memval(e_a);
        check("resp_ack0", 16'(ack0), 16'(!win));
        check("resp_ack1", 16'(ack1), 16'(win));
        check("resp_en", 16'(mem_en), 16'd0);
        check("resp_busy", 16'(busy), 16'd1);
        check("resp_rdata", rdata, m_rdata);
        check("resp_addr", mem_addr, e_a);
        if (!hold) begin
            if (win) req1 = 1'b0;
            else     req0 = 1'b0;
        end
        step();
        check("post_acks", {14'd0, ack1, ack0}, 16'd0);
        check("post_busy", 16'(busy), 16'd0);
        check("post_en", 16'(mem_en), 16'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_last  = 1'b1;
        m_rdata = 16'h0000;
        check("rst_en", 16'(mem_en), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_acks", {14'd0, ack1, ack0}, 16'd0);
        check("rst_rw", 16'(mem_rw), 16'd0);
        check("rst_addr", mem_addr, 16'd0);
        check("rst_wdata", mem_wdata, 16'd0);
        check("rst_rdata", rdata, 16'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;
        #2;
        do_reset();

        // Single read, single write, then a mid-access address change.
        txn(1, 0, 0, 0, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        txn(0, 1, 0, 1, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, 0, 0);
        txn(1, 0, 0, 0, 16'h3000, 16'h0000, 16'h5555, 16'h0000, 1, 0);
        check("mid_change_addr0", addr0, 16'h4000);

        // Tie right after reset: grants alternate starting with port 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 16'($urandom) % 2 == 1, 16'($urandom) % 2 == 1,
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 1);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Reset in the second access cycle aborts without an ack.
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0123;
        step();
        check("abort_grant_en", 16'(mem_en), 16'd1);
        step();
        check("abort_acc2_en", 16'(mem_en), 16'd1);
        rst = 1'b1;
        #1;
        m_last  = 1'b1;
        m_rdata = 16'h0000;
        check("abort_en", 16'(mem_en), 16'd0);
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_acks", {14'd0, ack1, ack0}, 16'd0);
        check("abort_rdata", rdata, 16'd0);
        step();
        check("abort_hold_acks", {14'd0, ack1, ack0}, 16'd0);
        rst = 1'b0;
        txn(1, 0, 0, 0, 16'h0123, 16'h0000, 16'h0000, 16'h0000, 0, 0);

        // Twenty idle clocks.
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_en", 16'(mem_en), 16'd0);
            check("idle_busy", 16'(busy), 16'd0);
            check("idle_acks", {14'd0, ack1, ack0}, 16'd0);
        end

        // Random traffic: unacked ports keep requesting, others request at random.
        for (int i = 0; i < 60; i++) begin
            txn(req0 | ($urandom_range(0, 1) == 1), req1 | ($urandom_range(0, 1) == 1),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    always @(negedge clk) begin
        if (n_checks > 0 && (ack0 && ack1)) begin
            n_checks++;
            n_fail++;
            $display("FAIL both_acks: observed ack0=%b ack1=%b expected not both high", ack0, ack1);
        end
    end

endmodule
